apb_master_arbiter: RTL and testbench
=====================================

Name: apb_master_arbiter

Overview:
- Multi-requester APB master that shares one APB3 completer, such as the GPIO/status register block, among NUM_REQ on-chip requesters (CPU bridge, debug port, DMA, ...).
- Arbitrates with a round-robin scheduler and sequences the SETUP/ACCESS phases.
- Honours PREADY wait states, aborts hung transfers with a watchdog, and returns read data plus error status to the winning requester.
- Sits between the requester fabric and the APB completer's PSEL/PENABLE/PADDR/PWDATA inputs.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
APB_ADDR_WIDTH, 5, PADDR width
APB_DATA_WIDTH, 32, PWDATA/PRDATA width
TIMEOUT_CYCLES, 16, max consecutive PREADY-low ACCESS cycles before abort; 0 disables watchdog

Ports:
gclk  in  1  clock (gated clock domain)
rstn  in  1  reset, synchronous, active-low
req_valid_i  in  NUM_REQ  per-requester transfer request
req_write_i  in  NUM_REQ  1=write, 0=read
req_addr_i  in  NUM_REQ*APB_ADDR_WIDTH  packed addresses, requester i at slice i
req_wdata_i  in  NUM_REQ*APB_DATA_WIDTH  packed write data
req_grant_o  out  NUM_REQ  one-hot, 1-cycle pulse: request accepted
rsp_valid_o  out  NUM_REQ  one-hot, 1-cycle pulse: transfer complete
rsp_rdata_o  out  APB_DATA_WIDTH  read data, valid with rsp_valid_o
rsp_err_o  out  1  PSLVERR or timeout, valid with rsp_valid_o
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  APB_ADDR_WIDTH  APB address
PWDATA  out  APB_DATA_WIDTH  APB write data
PRDATA  in  APB_DATA_WIDTH  APB read data
PREADY  in  1  completer ready
PSLVERR  in  1  completer error

Behaviour:
- Reset: rstn sampled low at a gclk edge sets state IDLE and clears every output to 0 (grants, responses, rdata, err, PSEL, PENABLE, PWRITE, PADDR, PWDATA). It also clears the watchdog and sets last_grant=NUM_REQ-1, so requester 0 has first priority.
- Reset mid-transfer: the transfer is dropped and no rsp_valid_o is issued. Requesters must re-request.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any req_valid_i is high, pick the winner by round-robin: search from last_grant+1 upward with wrap-around at NUM_REQ-1 to 0.
  - Latch the winner's write/addr/wdata and winner index, update last_grant, go to SETUP.
  - APB outputs are 0 in IDLE.
- SETUP:
  - PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA driven from latched values.
  - req_grant_o[winner]=1 for exactly this cycle.
  - Go to ACCESS unconditionally.
- ACCESS:
  - PSEL=1, PENABLE=1, address/data/direction held stable.
  - PREADY=1: sample PRDATA (reads) and PSLVERR, go to IDLE.
  - PREADY=0: stay in ACCESS and increment the watchdog.
- Completion, first IDLE cycle after ACCESS:
  - rsp_valid_o[winner]=1 for one cycle.
  - rsp_err_o=PSLVERR.
  - rsp_rdata_o=PRDATA for reads, 0 for writes and for errored reads.
  - rsp_rdata_o/rsp_err_o hold their value until the next completion.
- Watchdog:
  - Counts consecutive ACCESS cycles with PREADY=0; cleared on entering SETUP.
  - If the count reaches TIMEOUT_CYCLES with PREADY still 0, abort: go to IDLE, issue rsp_valid_o with rsp_err_o=1 and rsp_rdata_o=0.
  - Counter width is clog2(TIMEOUT_CYCLES+1) and saturates. TIMEOUT_CYCLES=0 waits forever.
- Latency: request seen in IDLE at cycle T → SETUP T+1 → ACCESS T+2 → (zero-wait) rsp_valid_o at T+3, IDLE at T+3. The next arbitration may occur at T+3, so peak throughput is 1 transfer per 3 cycles.
- Requester rule: hold req_valid_i and its fields stable until req_grant_o. Deassert or present a new request after grant. A request still high in the completion/IDLE cycle is treated as a new request.
- Simultaneous events:
  - Requests arriving during SETUP/ACCESS wait. A request deasserted before grant is never issued.
  - rsp_valid_o for winner A and a new arbitration in the same IDLE cycle are allowed; the grant appears in the following cycle.
- Lockstep: only one transfer is outstanding at a time. PSEL never drops between SETUP and ACCESS of one transfer.

Test Plan:
- Single write: req 0 write addr 0x04 data 0xDEADBEEF, PREADY=1 → PSEL rises T+1, PENABLE T+2, PADDR=0x04/PWDATA=0xDEADBEEF held both cycles; grant[0] at T+1, rsp_valid[0] at T+3, err=0.
- Single read with 2 wait states: req 1 read 0x00, PREADY low 2 ACCESS cycles then high with PRDATA=0x12345678 → ACCESS lasts 3 cycles, rsp_rdata=0x12345678, rsp_valid[1] once.
- Round robin: both requesters held continuously for 4 transfers after reset → grant order 0,1,0,1; no starvation; APB transfers non-overlapping.
- PSLVERR: read 0x10 answered PREADY=1, PSLVERR=1, PRDATA=0xFFFFFFFF → rsp_err=1, rsp_rdata=0.
- Timeout (TIMEOUT_CYCLES=16): PREADY held 0 → abort after 16 ACCESS cycles; PSEL/PENABLE drop; rsp_valid with err=1, rdata=0; the next request proceeds normally.
- Reset mid-ACCESS: rstn low for 1 cycle during a wait-stated read → all outputs 0 next cycle, no rsp_valid; after release, requester 0 wins first.

Source files
------------

// File: rtl/apb_master_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | apb_master_arbiter: round-robin arbiter sharing one APB3 completer among    |
// | NUM_REQ requesters, with PREADY wait states and an ACCESS-phase watchdog.   |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module apb_master_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int APB_ADDR_WIDTH = 5,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                gclk,
    input  logic                                rstn,
    input  logic [NUM_REQ-1:0]                  req_valid_i,
    input  logic [NUM_REQ-1:0]                  req_write_i,
    input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [NUM_REQ*APB_DATA_WIDTH-1:0]   req_wdata_i,
    output logic [NUM_REQ-1:0]                  req_grant_o,
    output logic [NUM_REQ-1:0]                  rsp_valid_o,
    output logic [APB_DATA_WIDTH-1:0]           rsp_rdata_o,
    output logic                                rsp_err_o,
    output logic                                PSEL,
    output logic                                PENABLE,
    output logic                                PWRITE,
    output logic [APB_ADDR_WIDTH-1:0]           PADDR,
    output logic [APB_DATA_WIDTH-1:0]           PWDATA,
    input  logic [APB_DATA_WIDTH-1:0]           PRDATA,
    input  logic                                PREADY,
    input  logic                                PSLVERR
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WDW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [IDXW-1:0]            last_grant_q, last_grant_d;
    logic [IDXW-1:0]            win_q, win_d;
    logic                       wr_q, wr_d;
    logic [APB_ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [APB_DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [WDW-1:0]             wdog_q, wdog_d;
    logic [NUM_REQ-1:0]         rsp_valid_q, rsp_valid_d;
    logic [APB_DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic                       rsp_err_q, rsp_err_d;

    logic [IDXW-1:0]            arb_win;
    logic                       arb_found;
    logic [WDW-1:0]             wdog_inc;
    logic                       wdog_hit;

    // Round-robin search starting one past the previous winner.
    always_comb begin
        arb_win   = last_grant_q;
        arb_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            logic [IDXW-1:0] cand;
            cand = IDXW'((int'(last_grant_q) + k) % NUM_REQ);
            if (!arb_found && req_valid_i[cand]) begin
                arb_found = 1'b1;
                arb_win   = cand;
            end
        end
    end

    assign wdog_inc = (wdog_q == {WDW{1'b1}}) ? wdog_q : wdog_q + 1'b1;
    assign wdog_hit = (TIMEOUT_CYCLES != 0) && (wdog_inc == WDW'(TIMEOUT_CYCLES));

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        win_d        = win_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wdog_d       = wdog_q;
        rsp_valid_d  = '0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    win_d        = arb_win;
                    last_grant_d = arb_win;
                    wr_d         = req_write_i[arb_win];
                    addr_d       = req_addr_i[arb_win*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
                    wdata_d      = req_wdata_i[arb_win*APB_DATA_WIDTH +: APB_DATA_WIDTH];
                    state_d      = SETUP;
                end
            end
            SETUP: begin
                wdog_d  = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    rsp_valid_d[win_q] = 1'b1;
                    rsp_err_d          = PSLVERR;
                    rsp_rdata_d        = (!wr_q && !PSLVERR) ? PRDATA : '0;
                    state_d            = IDLE;
                end else if (wdog_hit) begin
                    // Hung completer: abandon the transfer and report an error.
                    rsp_valid_d[win_q] = 1'b1;
                    rsp_err_d          = 1'b1;
                    rsp_rdata_d        = '0;
                    state_d            = IDLE;
                end else begin
                    wdog_d = wdog_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge gclk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            last_grant_q <= IDXW'(NUM_REQ - 1);
            win_q        <= '0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wdog_q       <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            win_q        <= win_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wdog_q       <= wdog_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    always_comb begin
        req_grant_o = '0;
        if (state_q == SETUP) begin
            req_grant_o[win_q] = 1'b1;
        end
    end

    // APB outputs are forced to zero whenever no transfer is in flight.
    assign PSEL        = (state_q != IDLE);
    assign PENABLE     = (state_q == ACCESS);
    assign PWRITE      = PSEL & wr_q;
    assign PADDR       = PSEL ? addr_q  : '0;
    assign PWDATA      = PSEL ? wdata_q : '0;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
`default_nettype none
// Testbench for apb_master_arbiter: directed transfers against a simple APB
// completer model, with grant/response scoreboards checked by a monitor.
module tb_apb_master_arbiter;

    localparam int NR = 2;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            gclk;
    logic            rstn;
    logic [NR-1:0]   req_valid_i;
    logic [NR-1:0]   req_write_i;
    logic [NR*AW-1:0] req_addr_i;
    logic [NR*DW-1:0] req_wdata_i;
    logic [NR-1:0]   req_grant_o;
    logic [NR-1:0]   rsp_valid_o;
    logic [DW-1:0]   rsp_rdata_o;
    logic            rsp_err_o;
    logic            PSEL, PENABLE, PWRITE;
    logic [AW-1:0]   PADDR;
    logic [DW-1:0]   PWDATA;
    logic [DW-1:0]   PRDATA;
    logic            PREADY;
    logic            PSLVERR;

    apb_master_arbiter #(
        .NUM_REQ(NR), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
    ) dut (
        .gclk(gclk), .rstn(rstn),
        .req_valid_i(req_valid_i), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_grant_o(req_grant_o), .rsp_valid_o(rsp_valid_o),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    // Completer model: PREADY rises after wait_states low ACCESS cycles unless hung.
    int   wait_states;
    bit   hang;
    bit   slverr_v;
    logic [DW-1:0] prdata_v;
    int   acc_cnt;

    always @(posedge gclk) begin
        if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
    end
    assign PREADY  = PSEL && PENABLE && !hang && (acc_cnt >= wait_states);
    assign PSLVERR = slverr_v & PREADY;
    assign PRDATA  = prdata_v;

    int checks;
    int errors;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          idx;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    rsp_t exp_rsp_q[$];
    int   exp_gnt_q[$];
    rsp_t mon_r;
    int   mon_g;

    always @(negedge gclk) begin
        if (req_grant_o != '0) begin
            if (exp_gnt_q.size() == 0) begin
                chk("unexpected_grant", 64'(req_grant_o), 64'd0);
            end else begin
                mon_g = exp_gnt_q.pop_front();
                chk("grant", 64'(req_grant_o), 64'd1 << mon_g);
            end
        end
        if (rsp_valid_o != '0) begin
            if (exp_rsp_q.size() == 0) begin
                chk("unexpected_rsp", 64'(rsp_valid_o), 64'd0);
            end else begin
                mon_r = exp_rsp_q.pop_front();
                chk("rsp_valid", 64'(rsp_valid_o), 64'd1 << mon_r.idx);
                chk("rsp_err",   64'(rsp_err_o),   64'(mon_r.err));
                chk("rsp_rdata", 64'(rsp_rdata_o), 64'(mon_r.rdata));
            end
        end
    end

    task automatic set_req(input int idx, input bit wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata);
        req_valid_i[idx]            = 1'b1;
        req_write_i[idx]            = wr;
        req_addr_i[idx*AW +: AW]    = addr;
        req_wdata_i[idx*DW +: DW]   = wdata;
    endtask

    task automatic push_exp(input int idx, input bit err, input logic [31:0] rdata);
        rsp_t r;
        r.idx = idx; r.err = err; r.rdata = rdata;
        exp_gnt_q.push_back(idx);
        exp_rsp_q.push_back(r);
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge gclk);
            if (req_grant_o != '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("grant_timeout", 64'd0, 64'd1);
    endtask

    // Issue one transfer from a single requester and return its ACCESS length.
    task automatic run_xfer(input int idx, input bit wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input bit exp_err,
                            input logic [31:0] exp_rdata, output int acc);
        bit ok;
        acc = 0;
        @(negedge gclk);
        set_req(idx, wr, addr, wdata);
        push_exp(idx, exp_err, exp_rdata);
        wait_grant(ok);
        req_valid_i = '0;
        if (ok) begin
            for (int i = 0; i < 60; i++) begin
                @(negedge gclk);
                if (PSEL && PENABLE) acc++;
                else break;
            end
        end
    endtask

    int  acc;
    bit  ok;

    initial begin
        checks = 0; errors = 0;
        rstn = 1'b0;
        req_valid_i = '0; req_write_i = '0; req_addr_i = '0; req_wdata_i = '0;
        wait_states = 0; hang = 1'b0; slverr_v = 1'b0; prdata_v = 32'hCAFE_0000;

        repeat (2) @(negedge gclk);
        chk("reset_psel",   64'(PSEL), 64'd0);
        chk("reset_pen",    64'(PENABLE), 64'd0);
        chk("reset_paddr",  64'(PADDR), 64'd0);
        chk("reset_grant",  64'(req_grant_o), 64'd0);
        chk("reset_rsp",    64'(rsp_valid_o), 64'd0);
        rstn = 1'b1;

        // Single zero-wait write: cycle-exact phase checks.
        @(negedge gclk);
        set_req(0, 1'b1, 5'h04, 32'hDEADBEEF);
        push_exp(0, 1'b0, 32'h0);
        @(negedge gclk);
        chk("w_setup_psel", 64'(PSEL), 64'd1);
        chk("w_setup_pen",  64'(PENABLE), 64'd0);
        chk("w_setup_addr", 64'(PADDR), 64'h04);
        chk("w_setup_data", 64'(PWDATA), 64'hDEADBEEF);
        chk("w_setup_pwr",  64'(PWRITE), 64'd1);
        chk("w_setup_gnt",  64'(req_grant_o), 64'b01);
        req_valid_i = '0;
        @(negedge gclk);
        chk("w_acc_pen",  64'(PENABLE), 64'd1);
        chk("w_acc_addr", 64'(PADDR), 64'h04);
        chk("w_acc_data", 64'(PWDATA), 64'hDEADBEEF);
        @(negedge gclk);
        chk("w_done_rsp",  64'(rsp_valid_o), 64'b01);
        chk("w_done_psel", 64'(PSEL), 64'd0);

        // Read with two wait states.
        wait_states = 2; prdata_v = 32'h12345678;
        run_xfer(1, 1'b0, 5'h00, 32'h0, 1'b0, 32'h12345678, acc);
        chk("r_wait_acc_len", 64'(acc), 64'd3);

        // Completer error on a read: data is suppressed.
        wait_states = 0; slverr_v = 1'b1; prdata_v = 32'hFFFFFFFF;
        run_xfer(0, 1'b0, 5'h10, 32'h0, 1'b1, 32'h0, acc);
        chk("slverr_acc_len", 64'(acc), 64'd1);
        slverr_v = 1'b0;

        // Hung completer triggers the watchdog after 16 ACCESS cycles.
        hang = 1'b1;
        run_xfer(1, 1'b0, 5'h08, 32'h0, 1'b1, 32'h0, acc);
        chk("timeout_acc_len", 64'(acc), 64'd16);
        hang = 1'b0;

        // Next transfer after the abort completes normally.
        wait_states = 1; prdata_v = 32'hA5A50001;
        run_xfer(0, 1'b0, 5'h0C, 32'h0, 1'b0, 32'hA5A50001, acc);
        chk("post_to_acc_len", 64'(acc), 64'd2);

        // Reset during a wait-stated read: transfer dropped, no response.
        wait_states = 5;
        @(negedge gclk);
        set_req(0, 1'b0, 5'h14, 32'h0);
        exp_gnt_q.push_back(0);
        wait_grant(ok);
        req_valid_i = '0;
        repeat (2) @(negedge gclk);
        chk("pre_rst_in_access", 64'(PENABLE), 64'd1);
        rstn = 1'b0;
        @(negedge gclk);
        chk("mid_rst_psel",  64'(PSEL), 64'd0);
        chk("mid_rst_pen",   64'(PENABLE), 64'd0);
        chk("mid_rst_paddr", 64'(PADDR), 64'd0);
        chk("mid_rst_rdata", 64'(rsp_rdata_o), 64'd0);
        chk("mid_rst_rsp",   64'(rsp_valid_o), 64'd0);

        // After release both requesters hold requests: order must be 0,1,0,1.
        rstn = 1'b1;
        wait_states = 0; prdata_v = 32'h0BAD_F00D;
        set_req(0, 1'b1, 5'h01, 32'h100);
        set_req(1, 1'b1, 5'h02, 32'h200);
        for (int n = 0; n < 4; n++) push_exp(n % 2, 1'b0, 32'h0);
        for (int n = 0; n < 4; n++) begin
            wait_grant(ok);
            if (ok) chk("rr_paddr", 64'(PADDR), (n % 2 == 0) ? 64'h01 : 64'h02);
        end
        req_valid_i = '0;
        repeat (6) @(negedge gclk);

        chk("gnt_queue_empty", 64'(exp_gnt_q.size()), 64'd0);
        chk("rsp_queue_empty", 64'(exp_rsp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected completion");
        $fatal(1, "simulation timeout");
    end

endmodule
`default_nettype wire
